// File: rtl/uart_pkg.sv
// Shared UART constants and small elaboration-time helpers.
package uart_pkg;

    // Width of a UART character as seen by the bus and the transmit engine.
    localparam int unsigned UART_DATA_W = 8;

    // Pointer width for a power-of-two FIFO: address bits plus one wrap bit.
    function automatic int unsigned fifo_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH register array with a synchronous write port and a registered read port.
// The read register resets to zero and holds its value when no read is requested.
module fifo_ram
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = UART_DATA_W,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Storage write; contents are not reset and survive flushes.
    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read; a same-edge write to the same slot returns the old entry.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the UART transmit engine: one-cycle read strobe, registered
// data/valid on the following cycle, registered level/flags and sticky error bits.
module tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH     = UART_DATA_W,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AFULL_LVL = 12
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     wen_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic                     full_o,
    output logic                     almost_full_o,
    input  logic                     ren_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     rvalid_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int unsigned PW = fifo_ptr_w(DEPTH);
    localparam int unsigned AW = PW - 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] AFULL_THR = PW'(AFULL_LVL);

    logic [PW-1:0] r_wptr, r_rptr, r_level;
    logic          r_empty, r_full, r_afull, r_rvalid, r_ovf, r_unf;

    logic [PW-1:0] w_wptr_d, w_rptr_d, w_level_d;
    logic          w_rd_ok, w_wr_ok;
    logic          w_empty_d, w_full_d, w_afull_d, w_ovf_d, w_unf_d;

    // Accept decisions; flush blocks both sides so nothing moves on that edge.
    assign w_rd_ok = ren_i & ~r_empty & ~flush_i;
    assign w_wr_ok = wen_i & (~r_full | w_rd_ok) & ~flush_i;

    // Next pointers, occupancy and flags, all derived from the post-edge pointers.
    always_comb begin
        w_wptr_d = r_wptr;
        w_rptr_d = r_rptr;
        w_ovf_d  = r_ovf;
        w_unf_d  = r_unf;
        if (flush_i) begin
            w_wptr_d = '0;
            w_rptr_d = '0;
            w_ovf_d  = 1'b0;
            w_unf_d  = 1'b0;
        end else begin
            if (w_wr_ok) w_wptr_d = r_wptr + PTR_ONE;
            if (w_rd_ok) w_rptr_d = r_rptr + PTR_ONE;
            if (wen_i && !w_wr_ok) w_ovf_d = 1'b1;
            if (ren_i && r_empty) w_unf_d = 1'b1;
        end
        w_level_d = w_wptr_d - w_rptr_d;
        w_empty_d = (w_wptr_d == w_rptr_d);
        w_full_d  = (w_wptr_d[PW-1] != w_rptr_d[PW-1]) &&
                    (w_wptr_d[AW-1:0] == w_rptr_d[AW-1:0]);
        w_afull_d = (w_level_d >= AFULL_THR);
    end

    // Pointer, flag and valid-pulse state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_rvalid <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_wptr   <= w_wptr_d;
            r_rptr   <= w_rptr_d;
            r_level  <= w_level_d;
            r_empty  <= w_empty_d;
            r_full   <= w_full_d;
            r_afull  <= w_afull_d;
            r_rvalid <= w_rd_ok;
            r_ovf    <= w_ovf_d;
            r_unf    <= w_unf_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .i_we    (w_wr_ok),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (wdata_i),
        .i_re    (w_rd_ok),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (rdata_o)
    );

    assign full_o        = r_full;
    assign almost_full_o = r_afull;
    assign empty_o       = r_empty;
    assign level_o       = r_level;
    assign rvalid_o      = r_rvalid;
    assign overflow_o    = r_ovf;
    assign underflow_o   = r_unf;

endmodule
